mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
- Multi-cycle successor to the single-cycle MIPS top: one shared ALU, one unified instruction/data memory port with a req/ready handshake, and an explicit control FSM.
- Parametrised in address width and reset vector.
- Adds variable-latency memory stalls and a halt/illegal-instruction trap, which the single-cycle core lacks.
- Sits at processor top level; the memory model or bus bridge connects to the mem_* port.

Parameters:
ADDR_W, 32, width of PC and mem_addr in bits; byte-addressed; range 8..32
RESET_PC, 0, PC value loaded on reset; must be word-aligned

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  ADDR_W  byte address, bits [1:0] always 0
mem_wdata  output  32  store data
mem_rdata  input  32  read data, sampled on the edge where mem_ready=1
mem_ready  input  1  completes the current request
halted  output  1  core stopped (HALT instruction or trap)
illegal  output  1  stop cause was an illegal opcode or misaligned access
pc_out  output  ADDR_W  current PC, for debug

Behaviour:
- Reset (async): state=FETCH, PC=RESET_PC. mem_req, mem_we, halted and illegal are 0; mem_addr and mem_wdata are 0. All 32 registers clear to 0.
- Register $0 always reads 0; writes to it are discarded.
- FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Request and its address stay stable until mem_ready=1.
  - On that edge: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - Read rs and rt into A and B.
  - Sign-extend imm16.
  - Unknown opcode/funct: go to HALT with illegal=1.
- EXECUTE:
  - R-type: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00 (by shamt).
  - addi 0x08: A+imm.
  - lw 0x23 / sw 0x2B: address = A+imm.
  - beq 0x04 / bne 0x05: if the condition holds, PC<=PC+(imm<<2); then go to FETCH.
  - j 0x02: PC<={PC[ADDR_W-1:28], target, 2'b00}, truncated to ADDR_W; then go to FETCH.
  - halt, opcode 0x3F: go to HALT, illegal=0.
  - lw/sw address with [1:0]!=0: go to HALT, illegal=1, no memory access.
- MEM:
  - mem_req=1, mem_addr=computed address; sw drives mem_we=1 and mem_wdata=B.
  - Stall until mem_ready.
  - sw then goes to FETCH; lw latches MDR<=mem_rdata and goes to WRITEBACK.
- WRITEBACK:
  - R-type writes rd; addi and lw write rt.
  - Then go to FETCH.
- Latency with mem_ready tied high:
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne/j: 3 cycles.
  - Each stall cycle adds one.
- Arithmetic:
  - 32-bit two's complement; overflow wraps, no exception.
  - PC arithmetic is modulo 2^ADDR_W.
- HALT:
  - halted=1 and mem_req=0.
  - State is held until rst.
  - mem_ready in HALT is ignored.
- mem_ready while mem_req=0: ignored.
- rst mid-request: mem_req drops in the same cycle (async). No register write or PC update from the aborted instruction.

Optional Feature:
- Macro: MIPS_PERF_CNT_EN.
- When defined, the core adds two outputs:
  - cycle_count (32-bit): increments every non-HALT cycle.
  - instr_retired (32-bit): increments each time an instruction finishes (the transition into FETCH, or into HALT on the halt instruction).
- Both counters clear on rst and wrap at 2^32.
- When not defined, neither port nor counter logic exists and the behaviour is otherwise identical.

Test Plan:
- Reset, RESET_PC=0x40, mem_ready=1 -> first mem_addr=0x40, mem_we=0; halted=0, illegal=0.
- Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x10($0); halt, with mem_ready=1 -> write of 0x0000000C to addr 0x10 with mem_we=1; halted=1 after 3×4+4+3 = 19 cycles.
- lw $4,0x10($0) with mem_ready delayed 3 cycles in both FETCH and MEM -> request held stable for 4 cycles each; $4=0x0C; total 11 cycles.
- beq $1,$1,-1 at 0x100 -> next fetch address 0x100; bne $1,$1,-1 at 0x100 -> next fetch address 0x104.
- Opcode 0x3E, or lw from address 0x13 -> halted=1, illegal=1, no mem_req afterwards; only rst recovers.
- rst asserted during a FETCH stall -> mem_req=0 immediately; after release, fetch restarts at RESET_PC. With MIPS_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port of mips_multicycle_core: one request at a time,
// completed by mem_ready. The core is the master; a memory model or bus bridge is the slave.
interface mips_multicycle_core_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: shared ALU, one stallable memory port, halt/illegal trap.
// Optional MIPS_PERF_CNT_EN adds cycle_count and instr_retired outputs.
module mips_multicycle_core #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_core_if.master mem,
  output logic                   halted,
  output logic                   illegal,
  output logic [ADDR_W-1:0]      pc_out
`ifdef MIPS_PERF_CNT_EN
  ,
  output logic [31:0]            cycle_count,
  output logic [31:0]            instr_retired
`endif
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              illegal_q, illegal_d;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic [31:0]       rf_q [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [25:0] target;
  logic [31:0] imm_sext, br_off, pc_ext, jump32, ea, rtype_res;
  logic        legal;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign target   = ir_q[25:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign br_off   = {imm_sext[29:0], 2'b00};
  assign pc_ext   = 32'(pc_q);
  // Upper PC nibble is kept from the already-incremented PC, then truncated to ADDR_W.
  assign jump32   = (pc_ext & 32'hF000_0000) | {4'b0000, target, 2'b00};
  assign ea       = a_q + imm_sext;

  always_comb begin
    rtype_res = '0;
    case (funct)
      6'h20:   rtype_res = a_q + b_q;
      6'h22:   rtype_res = a_q - b_q;
      6'h24:   rtype_res = a_q & b_q;
      6'h25:   rtype_res = a_q | b_q;
      6'h2A:   rtype_res = {31'd0, $signed(a_q) < $signed(b_q)};
      6'h00:   rtype_res = b_q << shamt;
      default: rtype_res = '0;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      6'h00: legal = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                     (funct == 6'h25) || (funct == 6'h2A) || (funct == 6'h00);
      6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    case (state_q)
      S_FETCH: if (mem.mem_ready) begin
        ir_d    = mem.mem_rdata;
        pc_d    = pc_q + ADDR_W'(4);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rf_q[rs];
        b_d = rf_q[rt];
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        case (op)
          6'h00: begin alu_d = rtype_res; state_d = S_WB; end
          6'h08: begin alu_d = ea; state_d = S_WB; end
          6'h23, 6'h2B: begin
            alu_d = ea;
            if (ea[1:0] != 2'b00) begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end else begin
              state_d = S_MEM;
            end
          end
          6'h04, 6'h05: begin
            if ((a_q == b_q) == (op == 6'h04)) pc_d = pc_q + br_off[ADDR_W-1:0];
            state_d = S_FETCH;
          end
          6'h02: begin pc_d = jump32[ADDR_W-1:0]; state_d = S_FETCH; end
          6'h3F: state_d = S_HALT;
          default: begin state_d = S_HALT; illegal_d = 1'b1; end
        endcase
      end
      S_MEM: if (mem.mem_ready) begin
        if (op == 6'h23) begin
          mdr_d   = mem.mem_rdata;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (op == 6'h00) ? rd : rt;
        rf_wdata = (op == 6'h23) ? mdr_q : alu_q;
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_rf
    if (gi == 0) begin : g_zero
      assign rf_q[gi] = '0;
    end else begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rf_q[gi] <= '0;
        else if (rf_we && rf_waddr == 5'(gi)) rf_q[gi] <= rf_wdata;
      end
    end
  end

  // Gated by rst so an in-flight request drops the moment reset is asserted.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (!rst) begin
      if (state_q == S_FETCH) begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc_q;
      end else if (state_q == S_MEM) begin
        mem.mem_req  = 1'b1;
        mem.mem_we   = (op == 6'h2B);
        mem.mem_addr = alu_q[ADDR_W-1:0];
        if (op == 6'h2B) mem.mem_wdata = b_q;
      end
    end
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign pc_out  = pc_q;

`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cyc_cnt_q, ret_cnt_q;
  logic        retire;

  assign retire = (state_d == S_FETCH && state_q != S_FETCH) ||
                  (state_q == S_EXEC && op == 6'h3F);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      if (state_q != S_HALT) cyc_cnt_q <= cyc_cnt_q + 32'd1;
      if (retire)            ret_cnt_q <= ret_cnt_q + 32'd1;
    end
  end

  assign cycle_count   = cyc_cnt_q;
  assign instr_retired = ret_cnt_q;
`endif
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: memory model with programmable stall, transaction log, cycle timing.
module tb_mips_multicycle_core;
  localparam int unsigned       ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RST_PC = 32'h40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              halted, illegal;
  logic [ADDR_W-1:0] pc_out;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0]       cycle_count, instr_retired;
`endif

  mips_multicycle_core_if #(.ADDR_W(ADDR_W)) bus ();

  mips_multicycle_core #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem           (bus.master),
    .halted        (halted),
    .illegal       (illegal),
    .pc_out        (pc_out)
`ifdef MIPS_PERF_CNT_EN
    ,
    .cycle_count   (cycle_count),
    .instr_retired (instr_retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    int          start;
    int          fin;
    logic        stable;
  } txn_t;

  logic [31:0] mem_q [256];
  txn_t        log_q [$];
  txn_t        t;
  int          cyc, wait_cnt, stall_n, halt_cyc;
  logic [31:0] hold_addr;
  logic        hold_we, stable;
  int          checks = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model: answers after stall_n wait cycles, logs each completed request.
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      wait_cnt      = 0;
    end else begin
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      if (bus.mem_req) begin
        if (wait_cnt == 0) begin
          hold_addr = bus.mem_addr;
          hold_we   = bus.mem_we;
          stable    = 1'b1;
        end else if (bus.mem_addr !== hold_addr || bus.mem_we !== hold_we) begin
          stable = 1'b0;
        end
        if (wait_cnt >= stall_n) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_q[bus.mem_addr[9:2]];
          if (bus.mem_we) mem_q[bus.mem_addr[9:2]] = bus.mem_wdata;
          t.addr   = bus.mem_addr;
          t.we     = bus.mem_we;
          t.data   = bus.mem_we ? bus.mem_wdata : bus.mem_rdata;
          t.start  = cyc - wait_cnt;
          t.fin    = cyc;
          t.stable = stable;
          log_q.push_back(t);
          $display("txn cyc=%0d addr=0x%08h we=%0d data=0x%08h", cyc, t.addr, t.we, t.data);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      cyc++;
    end
  end

  task automatic hold_reset(input int stalls);
    rst     = 1'b1;
    stall_n = stalls;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 256; i++) mem_q[i] = '0;
    log_q.delete();
    cyc      = 0;
    halt_cyc = -1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem_q[addr[9:2]] = w;
  endtask

  logic [31:0] prog1 [5]  = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0010, 32'hFC00_0000};
  logic [31:0] prog2 [3]  = '{32'h8C04_0010, 32'hAC04_0020, 32'hFC00_0000};
  logic [31:0] prog6 [18] = '{32'h2001_FFFD, 32'h2002_0006, 32'h0022_1822, 32'h0022_2024,
                              32'h0022_2825, 32'h0022_302A, 32'h0041_382A, 32'h0002_4100,
                              32'h2000_0001, 32'hAC03_0000, 32'hAC04_0004, 32'hAC05_0008,
                              32'hAC06_000C, 32'hAC07_0010, 32'hAC08_0014, 32'hAC00_0018,
                              32'hFC00_0000, 32'hFC00_0000};
  logic [31:0] exp6 [7]   = '{32'hFFFF_FFF7, 32'h4, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h60, 32'h0};
  int          wr_idx;

  initial begin
    // Straight-line program: addi, addi, add, sw, halt.
    hold_reset(0);
    foreach (prog1[i]) put(RST_PC + 32'(4 * i), prog1[i]);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_pc", pc_out, RST_PC);
    release_reset();
    check("first_req", {31'd0, bus.mem_req}, 32'd1);
    check("first_addr", bus.mem_addr, 32'h40);
    check("first_we", {31'd0, bus.mem_we}, 32'd0);
    run(30);
    check("p1_halt_cyc", halt_cyc, 32'd19);
    check("p1_halted", {31'd0, halted}, 32'd1);
    check("p1_illegal", {31'd0, illegal}, 32'd0);
    check("p1_ntxn", log_q.size(), 32'd6);
    if (log_q.size() == 6) begin
      check("p1_addi_lat", log_q[1].start, 32'd4);
      check("p1_add_start", log_q[3].start, 32'd12);
      check("p1_sw_we", {31'd0, log_q[4].we}, 32'd1);
      check("p1_sw_addr", log_q[4].addr, 32'h10);
      check("p1_sw_data", log_q[4].data, 32'h0000_000C);
      check("p1_sw_lat", log_q[5].start, 32'd16);
    end
`ifdef MIPS_PERF_CNT_EN
    check("p1_cycle_count", cycle_count, 32'd19);
    check("p1_instr_retired", instr_retired, 32'd5);
`endif

    // lw with 3 stall cycles on every request, then store the loaded value.
    hold_reset(3);
    put(32'h10, 32'h0000_000C);
    foreach (prog2[i]) put(RST_PC + 32'(4 * i), prog2[i]);
    release_reset();
    run(40);
    check("p2_ntxn", log_q.size(), 32'd5);
    if (log_q.size() == 5) begin
      check("p2_fetch_hold", log_q[0].fin - log_q[0].start + 1, 32'd4);
      check("p2_fetch_stable", {31'd0, log_q[0].stable}, 32'd1);
      check("p2_rd_addr", log_q[1].addr, 32'h10);
      check("p2_rd_hold", log_q[1].fin - log_q[1].start + 1, 32'd4);
      check("p2_rd_stable", {31'd0, log_q[1].stable}, 32'd1);
      check("p2_lw_lat", log_q[2].start, 32'd11);
      check("p2_sw_addr", log_q[3].addr, 32'h20);
      check("p2_sw_data", log_q[3].data, 32'h0000_000C);
    end

    // j 0x100, then beq $1,$1,-1 loops onto itself.
    hold_reset(0);
    put(32'h40, 32'h0800_0040);
    put(32'h100, 32'h1021_FFFF);
    release_reset();
    run(12);
    check("beq_ntxn", log_q.size(), 32'd4);
    if (log_q.size() == 4) begin
      check("j_target", log_q[1].addr, 32'h100);
      check("j_lat", log_q[1].start, 32'd3);
      check("beq_target", log_q[2].addr, 32'h100);
      check("beq_lat", log_q[2].start, 32'd6);
    end

    // bne $1,$1,-1 falls through to a halt.
    hold_reset(0);
    put(32'h40, 32'h0800_0040);
    put(32'h100, 32'h1421_FFFF);
    put(32'h104, 32'hFC00_0000);
    release_reset();
    run(15);
    check("bne_ntxn", log_q.size(), 32'd3);
    if (log_q.size() == 3) check("bne_target", log_q[2].addr, 32'h104);
    check("bne_halt_cyc", halt_cyc, 32'd9);

    // Illegal opcode 0x3E traps from DECODE.
    hold_reset(0);
    check("recover_halted", {31'd0, halted}, 32'd0);
    put(32'h40, 32'hF800_0000);
    release_reset();
    run(10);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_illegal", {31'd0, illegal}, 32'd1);
    check("ill_halt_cyc", halt_cyc, 32'd2);
    check("ill_ntxn", log_q.size(), 32'd1);
    check("ill_req", {31'd0, bus.mem_req}, 32'd0);

    // Misaligned lw from 0x13 traps without a memory access.
    hold_reset(0);
    put(32'h40, 32'h8C04_0013);
    release_reset();
    run(10);
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_illegal", {31'd0, illegal}, 32'd1);
    check("mis_ntxn", log_q.size(), 32'd1);

    // Reset asserted in the middle of a stalled fetch.
    hold_reset(100);
    put(32'h40, 32'h2001_0005);
    release_reset();
    run(3);
    check("stall_req", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_req", {31'd0, bus.mem_req}, 32'd0);
    check("abort_pc", pc_out, RST_PC);
`ifdef MIPS_PERF_CNT_EN
    check("abort_cycle_count", cycle_count, 32'd0);
    check("abort_instr_retired", instr_retired, 32'd0);
`endif
    hold_reset(0);
    put(32'h40, 32'h2001_0005);
    release_reset();
    run(2);
    check("restart_ntxn", log_q.size(), 32'd1);
    if (log_q.size() >= 1) check("restart_addr", log_q[0].addr, 32'h40);

    // ALU mix: sub/and/or/slt/sll, write to $0, results stored to 0x00..0x18.
    hold_reset(0);
    foreach (prog6[i]) put(RST_PC + 32'(4 * i), prog6[i]);
    release_reset();
    run(120);
    check("alu_halted", {31'd0, halted}, 32'd1);
    wr_idx = 0;
    foreach (log_q[i]) begin
      if (log_q[i].we) begin
        if (wr_idx < 7) begin
          check($sformatf("alu_wr%0d_addr", wr_idx), log_q[i].addr, 32'(4 * wr_idx));
          check($sformatf("alu_wr%0d_data", wr_idx), log_q[i].data, exp6[wr_idx]);
        end
        wr_idx++;
      end
    end
    check("alu_nwr", wr_idx, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
